xgmii_rx_meter: RTL

Parametrised receive-side companion to the XGMII traffic generator in the measure path. It sits on one 64-bit XGMII RX interface at 156.25 MHz and delineates frames from start/terminate control characters. It classifies each frame as good or errored, keeps running totals, and latches per-second frame-rate (pps) and byte-rate (throughput) figures for the PCI user registers. One instance is used per port.

---
 rtl/xgmii_pkg.sv | 32 +++
 rtl/xgmii_rx_meter_if.sv | 17 +
 rtl/xgmii_rx_meter_rate_window.sv | 68 ++++++
 rtl/xgmii_rx_meter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/xgmii_pkg.sv
// ---------------------------------------------------------------------------
// xgmii_pkg
// Shared definitions for the XGMII receive meter: control characters seen on
// the 64-bit RX interface, the frame-delineation FSM state type and the
// default good-frame length limits.
// Ports: none (package).
// ---------------------------------------------------------------------------
package xgmii_pkg;

  // XGMII control characters (valid only when the lane's rxc bit is set,
  // except SFD which travels as an ordinary data byte)
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERROR = 8'hFE;
  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_SFD   = 8'hD5;

  // Good-frame length window, DA..FCS inclusive
  localparam int DEF_MIN_LEN = 64;
  localparam int DEF_MAX_LEN = 1518;

  // Frame delineation states:
  //   ST_IDLE - between frames, hunting for START in lane 0 or lane 4
  //   ST_PRE4 - START was in lane 4; this word carries the rest of preamble
  //   ST_DATA - inside the frame body, hunting for TERM
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE4 = 2'd1,
    ST_DATA = 2'd2
  } rx_state_e;

endpackage

// File: rtl/xgmii_rx_meter_if.sv
// ---------------------------------------------------------------------------
// xgmii_rx_meter_if
// One 64-bit XGMII receive bus. The PHY side drives it (master), the meter
// observes it (slave).
// Signals:
//   xgmii_rxd [63:0] - RX data, lane k = bits [8k+7:8k]
//   xgmii_rxc [7:0]  - RX control, bit k qualifies lane k
// ---------------------------------------------------------------------------
interface xgmii_rx_meter_if;

  logic [63:0] xgmii_rxd;
  logic [7:0]  xgmii_rxc;

  modport master (output xgmii_rxd, output xgmii_rxc);
  modport slave  (input  xgmii_rxd, input  xgmii_rxc);

endinterface

// File: rtl/xgmii_rx_meter_rate_window.sv
// ---------------------------------------------------------------------------
// rate_window
// Free-running one-second measurement window. Counts good frames and good
// bytes inside the current window and, on the last tick of the window,
// publishes them as the frame rate and byte rate of the completed window.
// Ports:
//   sys_clk        in   system clock
//   sys_rst        in   synchronous active-high reset
//   add_frame      in   a good frame ended this cycle
//   add_bytes      in   length of that frame (valid with add_frame)
//   win_pps        out  good frames in the last completed window
//   win_throughput out  good bytes in the last completed window
// ---------------------------------------------------------------------------
module rate_window #(
  parameter int CLK_FREQ = 156250000,
  parameter int CNT_W    = 32
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             add_frame,
  input  logic [CNT_W-1:0] add_bytes,
  output logic [CNT_W-1:0] win_pps,
  output logic [CNT_W-1:0] win_throughput
);

  localparam int TICK_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_FREQ - 1);

  logic [TICK_W-1:0] tick_q;
  logic [CNT_W-1:0]  acc_frames_q;
  logic [CNT_W-1:0]  acc_bytes_q;
  logic              wrap;

  // Saturating add so a stuck counter reads all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] cnt_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  assign wrap = (tick_q == TICK_LAST);

  // Tick counter and accumulators. On the wrap cycle the accumulators are
  // published and restart; a frame ending on that same cycle seeds the new
  // window rather than the one being published.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tick_q         <= '0;
      acc_frames_q   <= '0;
      acc_bytes_q    <= '0;
      win_pps        <= '0;
      win_throughput <= '0;
    end else begin
      tick_q <= wrap ? '0 : tick_q + 1'b1;
      if (wrap) begin
        win_pps        <= acc_frames_q;
        win_throughput <= acc_bytes_q;
        acc_frames_q   <= add_frame ? CNT_W'(1) : '0;
        acc_bytes_q    <= add_frame ? add_bytes : '0;
      end else if (add_frame) begin
        acc_frames_q <= cnt_add(acc_frames_q, CNT_W'(1));
        acc_bytes_q  <= cnt_add(acc_bytes_q, add_bytes);
      end
    end
  end

endmodule

// File: rtl/xgmii_rx_meter.sv
// ---------------------------------------------------------------------------
// xgmii_rx_meter
// Receive-side frame meter for one 64-bit XGMII port. Delineates frames from
// START/TERM control characters, classifies each as good or errored, keeps
// saturating running totals and per-second rate figures.
// Ports:
//   sys_clk        in   system clock (single domain, rising edge)
//   sys_rst        in   synchronous active-high reset
//   rx             in   XGMII RX bus (xgmii_rxd / xgmii_rxc), slave modport
//   stat_clr       in   one-cycle pulse clearing the running totals
//   rx_frames      out  total good frames
//   rx_bytes       out  total good bytes (DA..FCS)
//   rx_errors      out  total errored frames
//   rx_pps         out  good frames in the last completed window
//   rx_throughput  out  good bytes in the last completed window
//   rx_last_len    out  length of the most recent frame, good or bad
//   rx_frame_done  out  one-cycle pulse at each frame end
//   rx_frame_err   out  with rx_frame_done: 1 = frame was errored
// ---------------------------------------------------------------------------
module xgmii_rx_meter
  import xgmii_pkg::*;
#(
  parameter int CLK_FREQ = 156250000,
  parameter int CNT_W    = 32,
  parameter int LEN_W    = 16,
  parameter int MIN_LEN  = DEF_MIN_LEN,
  parameter int MAX_LEN  = DEF_MAX_LEN
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  xgmii_rx_meter_if.slave    rx,
  input  logic               stat_clr,
  output logic [CNT_W-1:0]   rx_frames,
  output logic [CNT_W-1:0]   rx_bytes,
  output logic [CNT_W-1:0]   rx_errors,
  output logic [CNT_W-1:0]   rx_pps,
  output logic [CNT_W-1:0]   rx_throughput,
  output logic [LEN_W-1:0]   rx_last_len,
  output logic               rx_frame_done,
  output logic               rx_frame_err
);

  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

  rx_state_e        state_q, state_n;
  logic [LEN_W-1:0] len_q, len_n;
  logic             err_q, err_n;
  logic             frame_end;
  logic             frame_bad;
  logic             term_hit;
  logic [2:0]       term_lane;
  logic [CNT_W-1:0] frames_base, bytes_base, errors_base;
  logic [CNT_W-1:0] frames_n, bytes_n, errors_n;
  logic [CNT_W-1:0] win_pps, win_throughput;

  function automatic logic [LEN_W-1:0] len_add(input logic [LEN_W-1:0] a,
                                               input logic [3:0] b);
    logic [LEN_W:0] sum;
    sum = {1'b0, a} + (LEN_W + 1)'(b);
    return sum[LEN_W] ? '1 : sum[LEN_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] cnt_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  // Frame delineation. In PRE4 and DATA the word is scanned from the lowest
  // lane up: the first TERM ends the frame, any other control character met
  // before it marks the frame errored, and anything after the TERM (such as a
  // back-to-back START) is deliberately ignored.
  always_comb begin
    state_n   = state_q;
    len_n     = len_q;
    err_n     = err_q;
    frame_end = 1'b0;
    term_hit  = 1'b0;
    term_lane = 3'd0;
    unique case (state_q)
      ST_IDLE: begin
        if (rx.xgmii_rxc[0] && rx.xgmii_rxd[7:0] == XGMII_START) begin
          state_n = ST_DATA;
          len_n   = '0;
          err_n   = (rx.xgmii_rxd[63:56] != XGMII_SFD);
        end else if (rx.xgmii_rxc[4] && rx.xgmii_rxd[39:32] == XGMII_START) begin
          state_n = ST_PRE4;
          len_n   = '0;
          err_n   = 1'b0;
        end
      end
      ST_PRE4: begin
        err_n = (rx.xgmii_rxd[31:24] != XGMII_SFD);
        for (int k = 4; k < 8; k++) begin
          if (!term_hit && rx.xgmii_rxc[k]) begin
            if (rx.xgmii_rxd[8*k +: 8] == XGMII_TERM) begin
              term_hit  = 1'b1;
              term_lane = 3'(k);
            end else begin
              err_n = 1'b1;
            end
          end
        end
        if (term_hit) begin
          frame_end = 1'b1;
          len_n     = LEN_W'(term_lane - 3'd4);
          state_n   = ST_IDLE;
        end else begin
          len_n   = LEN_W'(4);
          state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        for (int k = 0; k < 8; k++) begin
          if (!term_hit && rx.xgmii_rxc[k]) begin
            if (rx.xgmii_rxd[8*k +: 8] == XGMII_TERM) begin
              term_hit  = 1'b1;
              term_lane = 3'(k);
            end else begin
              err_n = 1'b1;
            end
          end
        end
        if (term_hit) begin
          frame_end = 1'b1;
          len_n     = len_add(len_q, {1'b0, term_lane});
          state_n   = ST_IDLE;
        end else begin
          len_n = len_add(len_q, 4'd8);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign frame_bad = err_n || (len_n < MIN_L) || (len_n > MAX_L);

  // Running totals. A clear pulse wipes the old value first so a frame that
  // ends on the same cycle is still counted afterwards.
  always_comb begin
    frames_base = stat_clr ? '0 : rx_frames;
    bytes_base  = stat_clr ? '0 : rx_bytes;
    errors_base = stat_clr ? '0 : rx_errors;
    frames_n    = frames_base;
    bytes_n     = bytes_base;
    errors_n    = errors_base;
    if (frame_end && !frame_bad) begin
      frames_n = cnt_add(frames_base, CNT_W'(1));
      bytes_n  = cnt_add(bytes_base, CNT_W'(len_n));
    end
    if (frame_end && frame_bad) begin
      errors_n = cnt_add(errors_base, CNT_W'(1));
    end
  end

  // FSM state, frame accumulators and registered frame-end reporting
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q       <= ST_IDLE;
      len_q         <= '0;
      err_q         <= 1'b0;
      rx_frames     <= '0;
      rx_bytes      <= '0;
      rx_errors     <= '0;
      rx_last_len   <= '0;
      rx_frame_done <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      state_q       <= state_n;
      len_q         <= len_n;
      err_q         <= err_n;
      rx_frames     <= frames_n;
      rx_bytes      <= bytes_n;
      rx_errors     <= errors_n;
      rx_frame_done <= frame_end;
      rx_frame_err  <= frame_end && frame_bad;
      if (frame_end) begin
        rx_last_len <= len_n;
      end
    end
  end

  rate_window #(
    .CLK_FREQ (CLK_FREQ),
    .CNT_W    (CNT_W)
  ) u_rate_window (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .add_frame      (frame_end && !frame_bad),
    .add_bytes      (CNT_W'(len_n)),
    .win_pps        (win_pps),
    .win_throughput (win_throughput)
  );

  assign rx_pps        = win_pps;
  assign rx_throughput = win_throughput;

endmodule
